// File: rtl/imem_pkg.sv
// imem_pkg: fault codes, loader states and default NOP for the instruction memory.
package imem_pkg;
  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_RANGE    = 2'b10;
  localparam logic [1:0] FLT_PARITY   = 2'b11;
  localparam logic [31:0] IMEM_NOP    = 32'h0000_0013;
  typedef enum logic [1:0] {LD_IDLE, LD_LOAD, LD_DONE} ld_state_e;
endpackage

// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader; assembles little-endian words and writes them from address 0.
module imem_loader import imem_pkg::*; #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1,
  localparam int BW = $clog2(XLEN / 8)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_start,
  input  logic [LW-1:0]   ld_len,
  input  logic            ld_valid,
  input  logic [7:0]      ld_byte,
  output logic            ld_ready,
  output logic            ld_done,
  output logic            cpu_hold,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [XLEN-1:0] wr_data
);
  ld_state_e state_q, state_d;
  logic [LW-1:0] len_q, len_d, ptr_q, ptr_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] buf_q, buf_d;
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    buf_d = buf_q;
    wr_en = 1'b0;
    wr_addr = ptr_q[AW-1:0];
    wr_data = buf_q;
    wr_data[{cnt_q, 3'b000} +: 8] = ld_byte;
    ld_ready = state_q == LD_LOAD;
    ld_done = state_q == LD_DONE;
    cpu_hold = state_q != LD_IDLE;
    if (state_q == LD_IDLE && ld_start) begin
      len_d = ld_len > LW'(DEPTH) ? LW'(DEPTH) : ld_len;
      ptr_d = '0;
      cnt_d = '0;
      state_d = ld_len == '0 ? LD_DONE : LD_LOAD;
    end else if (state_q == LD_LOAD && ld_valid) begin
      buf_d = wr_data;
      cnt_d = cnt_q + BW'(1);
      if (cnt_q == BW'(XLEN / 8 - 1)) begin
        wr_en = 1'b1;
        ptr_d = ptr_q + LW'(1);
        state_d = ptr_d == len_q ? LD_DONE : LD_LOAD;
      end
    end else if (state_q == LD_DONE) begin
      state_d = LD_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LD_IDLE;
      len_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      buf_q <= '0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
  end
endmodule

// File: rtl/instr_mem_sync.sv
// instr_mem_sync: synchronous instruction memory with registered fetch port and byte-stream loader.
module instr_mem_sync import imem_pkg::*; #(
  parameter int          XLEN      = 32,
  parameter int          ADDR_W    = 32,
  parameter int          DEPTH     = 256,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(IMEM_NOP),
  parameter string       INIT_FILE = "",
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              fetch_valid,
  output logic [XLEN-1:0]   fetch_instr,
  output logic [1:0]        fetch_fault,
  output logic              cpu_hold,
  input  logic              ld_start,
  input  logic [AW:0]       ld_len,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  output logic              ld_ready,
  output logic              ld_done
);
`ifdef IMEM_PARITY_EN
  localparam int MW = XLEN + 1;
  function automatic logic [MW-1:0] pack(input logic [XLEN-1:0] d);
    return {^d, d};
  endfunction
`else
  localparam int MW = XLEN;
  function automatic logic [MW-1:0] pack(input logic [XLEN-1:0] d);
    return d;
  endfunction
`endif
  typedef logic [MW-1:0] mem_t [DEPTH];
  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) m[i] = pack(NOP_INSTR);
    return m;
  endfunction
  mem_t mem = init_mem();
  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic [XLEN-1:0] wr_data;
  imem_loader #(.XLEN(XLEN), .DEPTH(DEPTH)) u_loader (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_len(ld_len), .ld_valid(ld_valid),
    .ld_byte(ld_byte), .ld_ready(ld_ready), .ld_done(ld_done), .cpu_hold(cpu_hold),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= pack(wr_data);
  end
  logic fetch_valid_q, fetch_valid_d;
  logic [XLEN-1:0] fetch_instr_q, fetch_instr_d;
  logic [1:0] fetch_fault_q, fetch_fault_d;
  logic [MW-1:0] rd;
  logic fire, par_err;
  logic [1:0] flt;
  always_comb begin
    fire = fetch_req && !cpu_hold;
    rd = mem[fetch_pc[AW+1:2]];
`ifdef IMEM_PARITY_EN
    par_err = ^rd;
`else
    par_err = 1'b0;
`endif
    flt = fetch_pc[1:0] != 2'b00 ? FLT_MISALIGN :
          (fetch_pc >> 2) >= ADDR_W'(DEPTH) ? FLT_RANGE :
          par_err ? FLT_PARITY : FLT_NONE;
    fetch_valid_d = fire;
    fetch_fault_d = fire ? flt : FLT_NONE;
    fetch_instr_d = fire && flt == FLT_NONE ? rd[XLEN-1:0] : NOP_INSTR;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_valid_q <= 1'b0;
      fetch_instr_q <= NOP_INSTR;
      fetch_fault_q <= FLT_NONE;
    end else begin
      fetch_valid_q <= fetch_valid_d;
      fetch_instr_q <= fetch_instr_d;
      fetch_fault_q <= fetch_fault_d;
    end
  end
  assign fetch_valid = fetch_valid_q;
  assign fetch_instr = fetch_instr_q;
  assign fetch_fault = fetch_fault_q;
endmodule
